// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    Funct3B  = 3'b000,
    Funct3H  = 3'b001,
    Funct3W  = 3'b010,
    Funct3Bu = 3'b100,
    Funct3Hu = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    SzB,
    SzH,
    SzW
  } size_t;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StReq2,
    StWait2,
    StResp
  } lsu_state_t;

  // Byte-enable pattern of an access of the given size at lane 0.
  function automatic logic [3:0] size_mask(size_t sz);
    case (sz)
      SzB:     return 4'b0001;
      SzH:     return 4'b0011;
      SzW:     return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables and store-data placement from the access offset,
// plus read-data extraction and sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  size_t       i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [63:0] i_rdata,    // {second word, first word}
  output logic [7:0]  o_be8,      // [3:0] first word, [7:4] second word
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [4:0]  w_shamt;
  logic [63:0] w_wdata64;
  logic [31:0] w_rshift;

  assign w_shamt   = {i_off, 3'b000};
  assign o_be8     = {4'b0000, size_mask(i_size)} << i_off;
  // Rotation puts each byte on its lane for both the first and the spill-over word.
  assign w_wdata64 = {32'h0, i_wdata} << w_shamt;
  assign o_wdata   = w_wdata64[31:0] | w_wdata64[63:32];
  assign w_rshift  = 32'(i_rdata >> w_shamt);

  // Extend the extracted field to 32 bits.
  always_comb begin
    o_ldata = w_rshift;
    unique case (i_size)
      SzB:     o_ldata = i_unsigned ? {24'h0, w_rshift[7:0]}
                                    : {{24{w_rshift[7]}}, w_rshift[7:0]};
      SzH:     o_ldata = i_unsigned ? {16'h0, w_rshift[15:0]}
                                    : {{16{w_rshift[15]}}, w_rshift[15:0]};
      default: o_ldata = w_rshift;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes a memory instruction, drives a word-addressed req/gnt/rvalid bus
// and returns extended load data. One transaction in flight.
// Optional feature: LSU_MISALIGN_SPLIT_EN splits word-crossing H/W accesses into two beats;
// without it, misaligned H/W accesses complete with an error and no bus traffic.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] MEM_BASE = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [31:0]       i_req_instr,
  input  logic [31:0]       i_req_base,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [31:0]       o_rsp_addr,
  output logic              o_bus_req,
  input  logic              i_bus_gnt,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic              o_bus_we,
  output logic [3:0]        o_bus_be,
  output logic [31:0]       o_bus_wdata,
  input  logic              i_bus_rvalid,
  input  logic [31:0]       i_bus_rdata,
  input  logic              i_bus_err
);

  lsu_state_t        r_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_addr;
  logic              r_bus_req;
  logic [ADDR_W-1:0] r_bus_addr;
  logic              r_bus_we;
  logic [3:0]        r_bus_be;
  logic [31:0]       r_bus_wdata;
  logic [31:0]       r_ea;
  size_t             r_size;
  logic              r_unsigned;
  logic              r_we;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [3:0]        r_be_hi;
  logic [31:0]       r_rdata1;
`endif

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic        w_is_load;
  logic        w_is_store;
  logic [31:0] w_ea;
  size_t       w_size;
  logic        w_f3_ok;
  logic        w_err;
  logic        w_sel_new;
  size_t       w_al_size;
  logic [1:0]  w_al_off;
  logic [63:0] w_al_rdata;
  logic [7:0]  w_be8;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;
  logic        w_unused;

  assign w_opcode   = i_req_instr[6:0];
  assign w_funct3   = i_req_instr[14:12];
  assign w_imm_i    = {{20{i_req_instr[31]}}, i_req_instr[31:20]};
  assign w_imm_s    = {{20{i_req_instr[31]}}, i_req_instr[31:25], i_req_instr[11:7]};
  assign w_is_load  = (w_opcode == OP_LOAD);
  assign w_is_store = (w_opcode == OP_STORE);
  assign w_ea       = i_req_base + (w_is_store ? w_imm_s : w_imm_i);

  // Decode access size and legality of funct3 for the presented opcode.
  always_comb begin
    w_size  = SzB;
    w_f3_ok = 1'b0;
    case (w_funct3)
      Funct3B:  begin w_size = SzB; w_f3_ok = 1'b1;      end
      Funct3H:  begin w_size = SzH; w_f3_ok = 1'b1;      end
      Funct3W:  begin w_size = SzW; w_f3_ok = 1'b1;      end
      Funct3Bu: begin w_size = SzB; w_f3_ok = w_is_load; end
      Funct3Hu: begin w_size = SzH; w_f3_ok = w_is_load; end
      default:  begin w_size = SzB; w_f3_ok = 1'b0;      end
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_err    = !(w_is_load || w_is_store) || !w_f3_ok;
  assign w_unused = ^i_req_instr[19:15];
`else
  logic w_misalign;
  assign w_misalign = ((w_size == SzH) && w_ea[0]) || ((w_size == SzW) && (w_ea[1:0] != 2'b00));
  assign w_err      = !(w_is_load || w_is_store) || !w_f3_ok || w_misalign;
  assign w_unused   = ^{i_req_instr[19:15], w_be8[7:4]};
`endif

  // The aligner sees the incoming request while idle and the latched access otherwise.
  assign w_sel_new = (r_state == StIdle);
  assign w_al_size = w_sel_new ? w_size : r_size;
  assign w_al_off  = w_sel_new ? w_ea[1:0] : r_ea[1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_al_rdata = (r_state == StWait2) ? {i_bus_rdata, r_rdata1} : {32'h0, i_bus_rdata};
`else
  assign w_al_rdata = {32'h0, i_bus_rdata};
`endif

  lsu_align u_align (
    .i_size     (w_al_size),
    .i_off      (w_al_off),
    .i_unsigned (r_unsigned),
    .i_wdata    (i_req_wdata),
    .i_rdata    (w_al_rdata),
    .o_be8      (w_be8),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata)
  );

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_rsp_addr  <= 32'h0;
      r_bus_req   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_ea        <= 32'h0;
      r_size      <= SzB;
      r_unsigned  <= 1'b0;
      r_we        <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_be_hi     <= 4'h0;
      r_rdata1    <= 32'h0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            r_req_ready <= 1'b0;
            r_ea        <= w_ea;
            r_size      <= w_size;
            r_unsigned  <= w_funct3[2];
            r_we        <= w_is_store;
            if (w_err) begin
              r_state     <= StResp;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
              r_rsp_addr  <= w_ea + MEM_BASE;
            end else begin
              r_state     <= StReq;
              r_bus_req   <= 1'b1;
              r_bus_addr  <= {w_ea[ADDR_W-1:2], 2'b00};
              r_bus_we    <= w_is_store;
              r_bus_be    <= w_be8[3:0];
              r_bus_wdata <= w_is_store ? w_wdata : 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
              r_be_hi     <= w_be8[7:4];
`endif
            end
          end
        end
        StReq: begin
          if (i_bus_gnt) begin
            r_bus_req <= 1'b0;
            r_state   <= StWait;
          end
        end
        StWait: begin
          if (i_bus_rvalid) begin
            if (i_bus_err) begin
              r_state     <= StResp;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
              r_rsp_addr  <= r_ea + MEM_BASE;
`ifdef LSU_MISALIGN_SPLIT_EN
            end else if (r_be_hi != 4'h0) begin
              r_rdata1   <= i_bus_rdata;
              r_bus_req  <= 1'b1;
              r_bus_addr <= r_bus_addr + ADDR_W'(4);
              r_bus_be   <= r_be_hi;
              r_state    <= StReq2;
`endif
            end else begin
              r_state     <= StResp;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_rdata <= r_we ? 32'h0 : w_ldata;
              r_rsp_addr  <= r_ea + MEM_BASE;
            end
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        StReq2: begin
          if (i_bus_gnt) begin
            r_bus_req <= 1'b0;
            r_state   <= StWait2;
          end
        end
        StWait2: begin
          if (i_bus_rvalid) begin
            r_state     <= StResp;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= i_bus_err;
            r_rsp_rdata <= (i_bus_err || r_we) ? 32'h0 : w_ldata;
            r_rsp_addr  <= r_ea + MEM_BASE;
          end
        end
`endif
        StResp: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
          r_bus_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_addr  = r_rsp_addr;
  assign o_bus_req   = r_bus_req;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_we    = r_bus_we;
  assign o_bus_be    = r_bus_be;
  assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table driven through a bus responder, expected
// responses queued at accept and compared when rsp_valid pulses, plus reset corner cases.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_instr = '0;
  logic [31:0] i_req_base = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_rsp_addr;
  logic        o_bus_req;
  logic        i_bus_gnt = 1'b0;
  logic [31:0] o_bus_addr;
  logic        o_bus_we;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        i_bus_err = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_instr  (i_req_instr),
    .i_req_base   (i_req_base),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_rsp_addr   (o_rsp_addr),
    .o_bus_req    (o_bus_req),
    .i_bus_gnt    (i_bus_gnt),
    .o_bus_addr   (o_bus_addr),
    .o_bus_we     (o_bus_we),
    .o_bus_be     (o_bus_be),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata),
    .i_bus_err    (i_bus_err)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [1:0]  beats;
    logic [31:0] addr1;
    logic [3:0]  be1;
    logic [3:0]  be2;
    logic [31:0] bwdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];
  vec_t vt[14];

  function automatic logic [31:0] ld(input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'd1, f3, 5'd2, 7'b0000011};
  endfunction

  function automatic logic [31:0] st(input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], 5'd3, 5'd1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, base, wdata, rd1, rd2,
                              input logic [1:0] beats, input logic [31:0] addr1,
                              input logic [3:0] be1, be2, input logic [31:0] bwdata,
                              input logic err, input logic [31:0] erd, eaddr);
    vec_t v;
    v.instr = instr; v.base = base; v.wdata = wdata; v.rdata1 = rd1; v.rdata2 = rd2;
    v.beats = beats; v.addr1 = addr1; v.be1 = be1; v.be2 = be2; v.bwdata = bwdata;
    v.exp_err = err; v.exp_rdata = erd; v.exp_addr = eaddr;
    return v;
  endfunction

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v, input int gdly, input int rdly,
                         input logic berr);
    int n;
    int t0;
    exp_t e;
    logic [31:0] a;
    logic [3:0] b;
    logic [31:0] wd;
    logic bus_seen;
    logic is_st;
    is_st = (v.instr[6:0] == 7'b0100011);
    n = 0;
    while (!o_req_ready && n < 50) begin @(negedge clk); n++; end
    check($sformatf("v%0d req_ready before accept", idx), 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1;
    i_req_instr = v.instr;
    i_req_base  = v.base;
    i_req_wdata = v.wdata;
    t0 = cyc;
    @(negedge clk);
    i_req_valid = 1'b0;
    e.rdata = berr ? 32'h0 : v.exp_rdata;
    e.err   = v.exp_err | berr;
    e.addr  = v.exp_addr;
    sb_q.push_back(e);
    bus_seen = 1'b0;
    for (int bt = 0; bt < int'(v.beats); bt++) begin
      n = 0;
      while (!o_bus_req && n < 20) begin @(negedge clk); n++; end
      check($sformatf("v%0d beat%0d bus_req", idx, bt), 32'(o_bus_req), 32'd1);
      a = (bt == 0) ? v.addr1 : v.addr1 + 32'd4;
      b = (bt == 0) ? v.be1 : v.be2;
      check($sformatf("v%0d beat%0d bus_addr", idx, bt), o_bus_addr, a);
      check($sformatf("v%0d beat%0d bus_be", idx, bt), 32'(o_bus_be), 32'(b));
      check($sformatf("v%0d beat%0d bus_we", idx, bt), 32'(o_bus_we), 32'(is_st));
      if (is_st) check($sformatf("v%0d beat%0d bus_wdata", idx, bt), o_bus_wdata, v.bwdata);
      wd = o_bus_wdata;
      for (int d = 0; d < gdly; d++) begin
        // A stray rvalid while still requesting must be ignored.
        i_bus_rvalid = (d == 0);
        @(negedge clk);
        i_bus_rvalid = 1'b0;
        check($sformatf("v%0d hold%0d stable", idx, d),
              {o_bus_req, o_req_ready, o_bus_be, o_bus_addr[25:0]},
              {1'b1, 1'b0, b, a[25:0]});
        check($sformatf("v%0d hold%0d wdata", idx, d), o_bus_wdata, wd);
      end
      i_bus_gnt = 1'b1;
      @(negedge clk);
      i_bus_gnt = 1'b0;
      for (int d = 0; d < rdly; d++) @(negedge clk);
      i_bus_rvalid = 1'b1;
      i_bus_rdata  = (bt == 0) ? v.rdata1 : v.rdata2;
      i_bus_err    = berr;
      @(negedge clk);
      i_bus_rvalid = 1'b0;
      i_bus_rdata  = 32'h0;
      i_bus_err    = 1'b0;
      if (berr) break;
    end
    n = 0;
    while (!o_rsp_valid && n < 20) begin
      if (o_bus_req) bus_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    if (v.beats == 2'd0) check($sformatf("v%0d no bus traffic", idx), 32'(bus_seen | o_bus_req), 32'd0);
    check($sformatf("v%0d rsp_valid", idx), 32'(o_rsp_valid), 32'd1);
    if (o_rsp_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("v%0d rsp_rdata", idx), o_rsp_rdata, e.rdata);
      check($sformatf("v%0d rsp_err", idx), 32'(o_rsp_err), 32'(e.err));
      check($sformatf("v%0d rsp_addr", idx), o_rsp_addr, e.addr);
    end
    if (gdly == 0 && rdly == 0 && !berr)
      check($sformatf("v%0d latency", idx), 32'(cyc - t0), 32'(1 + 2 * int'(v.beats)));
    @(negedge clk);
    check($sformatf("v%0d rsp pulse/ready", idx), {31'h0, o_rsp_valid} | {30'h0, o_req_ready, 1'b0},
          32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = mk(st(3'b010, 12'h004), 32'h100, 32'hDEADBEEF, 32'h12345678, 0, 2'd1,
                32'h104, 4'hF, 4'h0, 32'hDEADBEEF, 1'b0, 32'h0, 32'h104);
    vt[1]  = mk(st(3'b000, 12'h003), 32'h100, 32'h000000A5, 0, 0, 2'd1,
                32'h100, 4'h8, 4'h0, 32'hA5000000, 1'b0, 32'h0, 32'h103);
    vt[2]  = mk(ld(3'b000, 12'h003), 32'h100, 0, 32'h80000000, 0, 2'd1,
                32'h100, 4'h8, 4'h0, 0, 1'b0, 32'hFFFFFF80, 32'h103);
    vt[3]  = mk(ld(3'b100, 12'h003), 32'h100, 0, 32'h80000000, 0, 2'd1,
                32'h100, 4'h8, 4'h0, 0, 1'b0, 32'h00000080, 32'h103);
    vt[4]  = mk(ld(3'b001, 12'h002), 32'h100, 0, 32'h80010000, 0, 2'd1,
                32'h100, 4'hC, 4'h0, 0, 1'b0, 32'hFFFF8001, 32'h102);
    vt[5]  = mk(ld(3'b101, 12'h002), 32'h100, 0, 32'h80010000, 0, 2'd1,
                32'h100, 4'hC, 4'h0, 0, 1'b0, 32'h00008001, 32'h102);
`ifdef LSU_MISALIGN_SPLIT_EN
    vt[6]  = mk(ld(3'b010, 12'h001), 32'h100, 0, 32'h44332211, 32'h88776655, 2'd2,
                32'h100, 4'hE, 4'h1, 0, 1'b0, 32'h55443322, 32'h101);
    vt[11] = mk(ld(3'b001, 12'h001), 32'h100, 0, 32'h00FF8000, 0, 2'd1,
                32'h100, 4'h6, 4'h0, 0, 1'b0, 32'hFFFFFF80, 32'h101);
`else
    vt[6]  = mk(ld(3'b010, 12'h001), 32'h100, 0, 0, 0, 2'd0,
                0, 4'h0, 4'h0, 0, 1'b1, 32'h0, 32'h101);
    vt[11] = mk(ld(3'b001, 12'h001), 32'h100, 0, 0, 0, 2'd0,
                0, 4'h0, 4'h0, 0, 1'b1, 32'h0, 32'h101);
`endif
    vt[7]  = mk(st(3'b001, 12'hFFE), 32'h200, 32'h1234ABCD, 0, 0, 2'd1,
                32'h1FC, 4'hC, 4'h0, 32'hABCD1234, 1'b0, 32'h0, 32'h1FE);
    vt[8]  = mk(ld(3'b011, 12'h000), 32'h300, 0, 0, 0, 2'd0,
                0, 4'h0, 4'h0, 0, 1'b1, 32'h0, 32'h300);
    vt[9]  = mk({7'b0, 5'd3, 5'd1, 3'b000, 5'd2, 7'b0110011}, 32'h40, 0, 0, 0, 2'd0,
                0, 4'h0, 4'h0, 0, 1'b1, 32'h0, 32'h43);
    vt[10] = mk(st(3'b100, 12'h000), 32'h80, 32'h1, 0, 0, 2'd0,
                0, 4'h0, 4'h0, 0, 1'b1, 32'h0, 32'h80);
    vt[12] = mk(ld(3'b010, 12'h010), 32'h0, 0, 32'hCAFEF00D, 0, 2'd1,
                32'h10, 4'hF, 4'h0, 0, 1'b0, 32'hCAFEF00D, 32'h10);
    vt[13] = mk(ld(3'b000, 12'h001), 32'h100, 0, 32'h00007F00, 0, 2'd1,
                32'h100, 4'h2, 4'h0, 0, 1'b0, 32'h0000007F, 32'h101);

    // Reset values while rst_n is held low.
    #12;
    check("reset req_ready", 32'(o_req_ready), 32'd1);
    check("reset rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("reset rsp_rdata", o_rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(o_rsp_err), 32'd0);
    check("reset rsp_addr", o_rsp_addr, 32'd0);
    check("reset bus_req", 32'(o_bus_req), 32'd0);
    check("reset bus_we", 32'(o_bus_we), 32'd0);
    check("reset bus_be", 32'(o_bus_be), 32'd0);
    check("reset bus_addr", o_bus_addr, 32'd0);
    check("reset bus_wdata", o_bus_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(i, vt[i], 0, 0, 1'b0);

    // Slow grant with stray rvalid during request, then bus errors.
    run_vec(20, vt[0], 3, 2, 1'b0);
    run_vec(21, vt[4], 2, 1, 1'b0);
    run_vec(22, vt[12], 0, 1, 1'b1);
    run_vec(23, vt[6], 1, 0, 1'b1);

    // Asynchronous reset in REQ (phase 0) and WAIT (phase 1); the late beat must be dropped.
    for (int ph = 0; ph < 2; ph++) begin
      int seen;
      i_req_valid = 1'b1;
      i_req_instr = vt[12].instr;
      i_req_base  = vt[12].base;
      @(negedge clk);
      i_req_valid = 1'b0;
      if (ph == 1) begin
        i_bus_gnt = 1'b1;
        @(negedge clk);
        i_bus_gnt = 1'b0;
      end
      check($sformatf("rst ph%0d bus_req before", ph), 32'(o_bus_req), 32'(ph == 0));
      rst_n = 1'b0;
      #1;
      check($sformatf("rst ph%0d bus_req dropped", ph), 32'(o_bus_req), 32'd0);
      check($sformatf("rst ph%0d req_ready", ph), 32'(o_req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      i_bus_rvalid = 1'b1;
      i_bus_rdata  = 32'h55AA55AA;
      @(negedge clk);
      i_bus_rvalid = 1'b0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
        if (o_rsp_valid || o_bus_req) seen++;
        @(negedge clk);
      end
      check($sformatf("rst ph%0d late beat ignored", ph), 32'(seen), 32'd0);
    end

    // Recovery after reset.
    run_vec(30, vt[2], 0, 0, 1'b0);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
